// File: rtl/instr_dispatch_if.sv
// Dispatcher bus: instruction-memory read port plus execution-FSM launch/done.
interface instr_dispatch_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] instr_addr;
    logic [15:0]       instr_data;
    logic [3:0]        FSM_start;
    logic [5:0]        source;
    logic [5:0]        dest;
    logic              fsm_done;

    modport master (
        output instr_addr,
        output FSM_start,
        output source,
        output dest,
        input  instr_data,
        input  fsm_done
    );

    modport slave (
        input  instr_addr,
        input  FSM_start,
        input  source,
        input  dest,
        output instr_data,
        output fsm_done
    );
endinterface

// File: rtl/instr_dispatch.sv
// Fetch/decode/launch sequencer for the execution FSMs.
// Optional WAIT_DONE watchdog enabled by defining INSTR_DISPATCH_TIMEOUT_EN.
module instr_dispatch #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    instr_dispatch_if.master bus,
    output logic             busy,
    output logic             halted,
    output logic             error
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        DECODE,
        ISSUE,
        WAIT_DONE,
        ADVANCE,
        HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [3:0]        fsm_start;
    logic [5:0]        source;
    logic [5:0]        dest;
    logic [3:0]        opcode;

    assign opcode = ir[15:12];

`ifdef INSTR_DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_count;
    logic            error_q;

    assign error = error_q;
`else
    wire [31:0] unused_timeout = TIMEOUT_CYCLES;

    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            fsm_start <= '0;
            source    <= '0;
            dest      <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
`ifdef INSTR_DISPATCH_TIMEOUT_EN
            wd_count  <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            fsm_start <= '0;
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    ir    <= bus.instr_data;
                    state <= DECODE;
                end
                DECODE: begin
                    source <= ir[11:6];
                    dest   <= ir[5:0];
                    unique case (1'b1)
                        (opcode == OP_NOP): begin
                            state <= ADVANCE;
                        end
                        (opcode == OP_HALT): begin
                            state  <= HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: begin
                            state     <= ISSUE;
                            fsm_start <= opcode;
                        end
                    endcase
                end
                ISSUE: begin
                    state    <= WAIT_DONE;
`ifdef INSTR_DISPATCH_TIMEOUT_EN
                    wd_count <= '0;
`endif
                end
                WAIT_DONE: begin
                    // a done landing on the limit cycle wins over the watchdog
                    if (bus.fsm_done) begin
                        state <= ADVANCE;
                    end
`ifdef INSTR_DISPATCH_TIMEOUT_EN
                    else if (wd_count == WD_LAST) begin
                        state   <= ADVANCE;
                        error_q <= 1'b1;
                    end else begin
                        wd_count <= wd_count + WD_W'(1);
                    end
`endif
                end
                ADVANCE: begin
                    pc <= pc + ADDR_W'(1);
                    if (run) begin
                        state <= FETCH;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_addr = pc;
    assign bus.FSM_start  = fsm_start;
    assign bus.source     = source;
    assign bus.dest       = dest;
endmodule
